// File: rtl/rtype_instr_writer.sv
// Assembles MIPS R-type instruction words from ALU-control requests and writes
// them sequentially into instruction memory, stopping once DEPTH words are stored.
module rtype_instr_writer #(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_cntl,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   wr_count,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_M1 = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        WR,
        FULL
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [3:0]        cntl_q;
    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] ptr;
    logic [5:0]        func;
    logic              legal;

    // Inverse of the R-type control decoder: ALU control code -> funct field.
    always_comb begin
        func  = '0;
        legal = 1'b1;
        case (cntl_q)
            4'b1010: func = 6'h20;
            4'b0010: func = 6'h21;
            4'b1110: func = 6'h22;
            4'b0110: func = 6'h23;
            4'b0000: func = 6'h24;
            4'b0001: func = 6'h25;
            4'b0011: func = 6'h26;
            4'b1100: func = 6'h27;
            4'b0101: func = 6'h2A;
            4'b1111: func = 6'h2B;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // im_we is decoded from the state so that both clear and reset kill it
    // within the cycle they appear, without waiting for an edge.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        im_we    = 1'b0;
        full     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = ENC;
                end
            end
            ENC: begin
                state_nx = legal ? WR : IDLE;
            end
            WR: begin
                im_we    = 1'b1;
                state_nx = (wr_count == DEPTH_M1) ? FULL : IDLE;
            end
            FULL: begin
                full = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (clear) begin
            state_nx = IDLE;
            im_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ptr       <= BASE;
            im_addr   <= BASE;
            im_wdata  <= '0;
            wr_count  <= '0;
            err_count <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clear) begin
                ptr       <= BASE;
                wr_count  <= '0;
                err_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            cntl_q <= alu_cntl;
                            rs_q   <= rs;
                            rt_q   <= rt;
                            rd_q   <= rd;
                        end
                    end
                    ENC: begin
                        if (legal) begin
                            im_wdata <= {6'b000000, rs_q, rt_q, rd_q, 5'b00000, func};
                            im_addr  <= ptr;
                        end else begin
                            err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end
                    WR: begin
                        ptr      <= ptr + 1'b1;
                        wr_count <= wr_count + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtype_instr_writer.sv
// Self-checking bench for rtype_instr_writer: vector table, randomized requests
// against a behavioural model, and hand sequences for clear/reset/full corners.
module tb_rtype_instr_writer;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_cntl;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              full;
    logic              err;
    logic [ADDR_W:0]   wr_count;
    logic [7:0]        err_count;

    rtype_instr_writer #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .BASE_ADDR(0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_cntl (alu_cntl),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .full     (full),
        .err      (err),
        .wr_count (wr_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0;

    always @(posedge clk) if (im_we === 1'b1) we_cnt++;

    // Reference model state
    int exp_ptr  = 0;
    int exp_wr   = 0;
    int exp_errc = 0;

    logic [3:0] codes [10] = '{4'b1010, 4'b0010, 4'b1110, 4'b0110, 4'b0000,
                               4'b0001, 4'b0011, 4'b1100, 4'b0101, 4'b1111};
    int         funcs [10] = '{'h20, 'h21, 'h22, 'h23, 'h24,
                               'h25, 'h26, 'h27, 'h2A, 'h2B};

    function automatic bit ref_enc(input logic [3:0] c, input logic [4:0] s,
                                   input logic [4:0] t, input logic [4:0] d,
                                   output logic [31:0] w);
        w = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (codes[i] == c) begin
                w = s * 32'h0020_0000 + t * 32'h0001_0000 + d * 32'h0000_0800 + funcs[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_ptr  = 0;
        exp_wr   = 0;
        exp_errc = 0;
    endtask

    // Entered and left at posedge+1.
    task automatic do_req(input logic [3:0] c, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input bit legal, input logic [31:0] word);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready=%b, expected 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        alu_cntl = c;
        rs = s;
        rt = t;
        rd = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_cntl = 4'($urandom);
        rs = 5'($urandom);
        rt = 5'($urandom);
        rd = 5'($urandom);
        chk("ready_fall", in_ready, 0);
        chk("enc_we", im_we, 0);
        @(posedge clk); #1;
        if (legal) begin
            chk("wr_we", im_we, 1);
            chk("wr_addr", im_addr, exp_ptr);
            chk("wr_data", im_wdata, word);
            chk("wr_ready", in_ready, 0);
            @(posedge clk); #1;
            exp_wr++;
            exp_ptr = (exp_ptr + 1) % (1 << ADDR_W);
            chk("post_we", im_we, 0);
            chk("wr_count", wr_count, exp_wr);
            chk("full", full, exp_wr == DEPTH);
            chk("post_ready", in_ready, exp_wr != DEPTH);
        end else begin
            if (exp_errc < 255) exp_errc++;
            chk("err_pulse", err, 1);
            chk("err_we", im_we, 0);
            chk("err_count", err_count, exp_errc);
            chk("err_ready", in_ready, 1);
            @(posedge clk); #1;
            chk("err_drop", err, 0);
            chk("err_wr_count", wr_count, exp_wr);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        chk("clr_wr_count", wr_count, 0);
        chk("clr_err_count", err_count, 0);
        chk("clr_full", full, 0);
        chk("clr_ready", in_ready, 1);
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [4:0]  s;
        logic [4:0]  t;
        logic [4:0]  d;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        bit          lg;
        int          we0;
        logic [3:0]  c;
        logic [4:0]  s, t, d;

        vecs[0] = '{4'b1010, 5'd1,  5'd2,  5'd3,  1'b1, 32'h0022_1820};
        vecs[1] = '{4'b1111, 5'd31, 5'd31, 5'd31, 1'b1, 32'h03FF_F82B};
        vecs[2] = '{4'b0111, 5'd4,  5'd5,  5'd6,  1'b0, 32'h0};
        vecs[3] = '{4'b0010, 5'd0,  5'd0,  5'd0,  1'b1, 32'h0000_0021};
        vecs[4] = '{4'b1001, 5'd9,  5'd9,  5'd9,  1'b0, 32'h0};

        reset = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        alu_cntl = '0;
        rs = '0;
        rt = '0;
        rd = '0;
        #1;
        chk("rst_we", im_we, 0);
        chk("rst_addr", im_addr, 0);
        chk("rst_wdata", im_wdata, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_ready", in_ready, 1);
        #11 reset = 1'b0;
        @(posedge clk); #1;
        model_reset();

        // Table vectors: legal writes, illegal code leaves the address unchanged
        for (int i = 0; i < 5; i++) begin
            do_req(vecs[i].c, vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].legal, vecs[i].word);
        end
        chk("tbl_err_count", err_count, 2);
        chk("tbl_wr_count", wr_count, 3);

        // Fill to DEPTH, then requests stall until clear
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            s = 5'($urandom);
            t = 5'($urandom);
            d = 5'($urandom);
            c = codes[$urandom_range(0, 9)];
            lg = ref_enc(c, s, t, d, w);
            do_req(c, s, t, d, lg, w);
        end
        in_valid = 1'b1;
        alu_cntl = 4'b1010;
        rs = 5'd4;
        rt = 5'd5;
        rd = 5'd6;
        we0 = we_cnt;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("stall_ready", in_ready, 0);
            chk("stall_full", full, 1);
        end
        chk("stall_no_write", we_cnt - we0, 0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        chk("fclr_ready", in_ready, 1);
        chk("fclr_full", full, 0);
        chk("fclr_wr_count", wr_count, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fclr_accept", in_ready, 0);
        @(posedge clk); #1;
        chk("fclr_we", im_we, 1);
        chk("fclr_addr", im_addr, 0);
        chk("fclr_data", im_wdata, 32'h0085_3020);
        @(posedge clk); #1;
        exp_ptr = 1;
        exp_wr  = 1;
        chk("fclr_wr_count1", wr_count, 1);

        // Clear together with a request in IDLE: not accepted until next cycle
        in_valid = 1'b1;
        clear = 1'b1;
        alu_cntl = 4'b0001;
        rs = 5'd2;
        rt = 5'd3;
        rd = 5'd4;
        chk("cv_ready_during", in_ready, 1);
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        chk("cv_not_accepted", in_ready, 1);
        chk("cv_wr_count", wr_count, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("cv_accepted", in_ready, 0);
        @(posedge clk); #1;
        chk("cv_we", im_we, 1);
        chk("cv_addr", im_addr, 0);
        chk("cv_data", im_wdata, 32'h0043_2025);
        @(posedge clk); #1;
        exp_ptr = 1;
        exp_wr  = 1;
        chk("cv_wr_count1", wr_count, 1);

        // Randomized requests against the model
        for (int i = 0; i < 60; i++) begin
            if (exp_wr == DEPTH) do_clear();
            c = 4'($urandom);
            s = 5'($urandom);
            t = 5'($urandom);
            d = 5'($urandom);
            lg = ref_enc(c, s, t, d, w);
            do_req(c, s, t, d, lg, w);
        end

        // Clear during WR aborts the write
        do_clear();
        in_valid = 1'b1;
        alu_cntl = 4'b1111;
        rs = 5'd7;
        rt = 5'd8;
        rd = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_wr", im_we, 1);
        we0 = we_cnt;
        clear = 1'b1;
        #1;
        chk("abort_we", im_we, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        chk("abort_no_write", we_cnt - we0, 0);
        chk("abort_wr_count", wr_count, 0);
        chk("abort_ready", in_ready, 1);

        // Reset during WR
        do_req(4'b0000, 5'd1, 5'd1, 5'd1, 1'b1, 32'h0021_0824);
        in_valid = 1'b1;
        alu_cntl = 4'b0011;
        rs = 5'd10;
        rt = 5'd11;
        rd = 5'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rwr_in_wr", im_we, 1);
        reset = 1'b1;
        #1;
        chk("rwr_we", im_we, 0);
        chk("rwr_addr", im_addr, 0);
        chk("rwr_wdata", im_wdata, 0);
        chk("rwr_wr_count", wr_count, 0);
        chk("rwr_err_count", err_count, 0);
        chk("rwr_ready", in_ready, 1);
        chk("rwr_full", full, 0);
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        lg = ref_enc(4'b0101, 5'd3, 5'd4, 5'd5, w);
        do_req(4'b0101, 5'd3, 5'd4, 5'd5, lg, w);

        // err_count saturation
        do_clear();
        for (int i = 0; i < 257; i++) begin
            do_req(4'b1000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        end
        chk("err_sat", err_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
